// File: rtl/twiddle_factor_index_pkg.sv
// Shared FFT sizing for the twiddle index generator slice.
package fft_pkg;
  localparam int N_POINTS = 64;
  localparam int LOG2_N   = 6;
  localparam int HALF_N   = N_POINTS / 2;

  typedef logic [LOG2_N-1:0] idx_t;
endpackage

// File: rtl/twiddle_factor_index_if.sv
// Stage/start request and twiddle ROM address bundle.
// Optional busy flag present when TWIDDLE_FACTOR_INDEX_BUSY_EN is defined.
interface twiddle_factor_index_if #(
  parameter int LOG2_N = fft_pkg::LOG2_N
);
  logic [LOG2_N-1:0] stage;
  logic              start;
  logic [LOG2_N-1:0] out;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
  logic              busy;

  modport master (output stage, output start, input  out, input  busy);
  modport slave  (input  stage, input  start, output out, output busy);
`else
  modport master (output stage, output start, input  out);
  modport slave  (input  stage, input  start, output out);
`endif
endinterface

// File: rtl/twiddle_factor_index_msb_encoder.sv
// Combinational priority encoder: index of the highest set bit plus zero flag.
module tfi_msb_encoder
  import fft_pkg::*;
#(
  parameter int W = LOG2_N
) (
  input  logic [W-1:0] i_stage,
  output logic [W-1:0] o_msb,
  output logic         o_zero
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    o_msb  = '0;
    o_zero = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (i_stage[i]) begin
        o_msb  = W'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/twiddle_factor_index.sv
// Twiddle-factor index generator for one radix-2 DIT FFT stage.
// Optional busy output built when TWIDDLE_FACTOR_INDEX_BUSY_EN is defined.
module twiddle_factor_index #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int LOG2_N   = fft_pkg::LOG2_N
) (
  input  logic                   clk,
  input  logic                   rst,
  twiddle_factor_index_if.slave  bus
);

  localparam int HALF = N_POINTS / 2;
  localparam int CW   = LOG2_N - 1;

  logic [LOG2_N-1:0] w_msb;
  logic              w_zero;
  logic [LOG2_N-1:0] w_exp;
  logic [LOG2_N-1:0] w_span;
  logic [LOG2_N-1:0] w_shift;
  logic [LOG2_N-1:0] w_mask;
  logic [LOG2_N-1:0] w_k;

  logic [CW-1:0]     r_j;
  logic              r_active;
  logic [LOG2_N-1:0] r_span;
  logic [LOG2_N-1:0] r_shift;
  logic [LOG2_N-1:0] r_out;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
  logic              r_busy;
`endif

  tfi_msb_encoder #(.W(LOG2_N)) u_enc (
    .i_stage (bus.stage),
    .o_msb   (w_msb),
    .o_zero  (w_zero)
  );

  // Normalise requested span to a power of two no larger than N/2, derive shift.
  always_comb begin
    w_exp   = (w_msb > LOG2_N'(CW)) ? LOG2_N'(CW) : w_msb;
    w_span  = w_zero ? '0 : (LOG2_N'(1) << w_exp);
    w_shift = w_zero ? '0 : (LOG2_N'(CW) - w_exp);
  end

  // Twiddle index for the current butterfly: (j mod S) scaled by N/(2S).
  always_comb begin
    w_mask = r_span - LOG2_N'(1);
    w_k    = (r_span == '0) ? '0 : (({1'b0, r_j} & w_mask) << r_shift);
  end

  // Sweep control: start latches span and emits k(0); running steps j once per edge.
  // busy tracks cycles carrying a sweep value, so it lags active by one edge at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_j      <= '0;
      r_active <= 1'b0;
      r_span   <= '0;
      r_shift  <= '0;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      r_busy   <= 1'b0;
`endif
    end else if (bus.start) begin
      r_out    <= '0;
      r_j      <= CW'(1);
      r_active <= 1'b1;
      r_span   <= w_span;
      r_shift  <= w_shift;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      r_busy   <= 1'b1;
`endif
    end else if (r_active) begin
      r_out <= w_k;
      r_j   <= r_j + CW'(1);
      if (r_j == CW'(HALF - 1)) r_active <= 1'b0;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      r_busy <= 1'b1;
`endif
    end else begin
      r_out <= '0;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      r_busy <= 1'b0;
`endif
    end
  end

  assign bus.out = r_out;
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
  assign bus.busy = r_busy;
`endif

endmodule

// File: tb/tb_twiddle_factor_index.sv
// Testbench for twiddle_factor_index; busy checks compiled when TWIDDLE_FACTOR_INDEX_BUSY_EN is defined.
module tb_twiddle_factor_index;
  import fft_pkg::*;

  localparam int N    = 64;
  localparam int LG   = 6;
  localparam int HALF = N / 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  twiddle_factor_index_if #(.LOG2_N(LG)) bus ();

  twiddle_factor_index #(.N_POINTS(N), .LOG2_N(LG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: largest power of two <= stage (capped at N/2); k = (j mod S) * (N/2)/S.
  function automatic int ref_k(input int stage_v, input int j);
    int s;
    s = 0;
    for (int p = 1; p <= HALF; p = p * 2)
      if (p <= stage_v) s = p;
    if (s == 0) return 0;
    return (j % s) * (HALF / s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stage = '0;
    tick();
    tick();
    checks++;
    if (bus.out !== '0) begin
      errors++;
      $display("FAIL reset_out got %0d want 0", bus.out);
    end
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b want 0", bus.busy);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  // Full sweep with stage scrambled randomly while running, then idle tail.
  task automatic test_sweep(input string name, input int stage_v);
    idx_t got;
    bus.stage = idx_t'(stage_v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < HALF; j++) begin
      got = bus.out;
      checks++;
      if (got !== idx_t'(ref_k(stage_v, j))) begin
        errors++;
        $display("FAIL %s stage=%0d j=%0d got %0d want %0d", name, stage_v, j, got, ref_k(stage_v, j));
      end
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy j=%0d got %0b want 1", name, j, bus.busy);
      end
`endif
      bus.stage = idx_t'($urandom_range(0, N - 1));
      if (j < HALF - 1) tick();
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (bus.out !== '0) begin
        errors++;
        $display("FAIL %s_idle t=%0d got %0d want 0", name, t, bus.out);
      end
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_idle_busy t=%0d got %0b want 0", name, t, bus.busy);
      end
`endif
    end
  endtask

  task automatic test_restart();
    bus.stage = idx_t'(32);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (bus.out !== idx_t'(ref_k(32, j))) begin
        errors++;
        $display("FAIL restart_pre j=%0d got %0d want %0d", j, bus.out, ref_k(32, j));
      end
      if (j < 5) tick();
    end
    bus.stage = idx_t'(4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < HALF; j++) begin
      checks++;
      if (bus.out !== idx_t'(ref_k(4, j))) begin
        errors++;
        $display("FAIL restart_post j=%0d got %0d want %0d", j, bus.out, ref_k(4, j));
      end
      if (j < HALF - 1) tick();
    end
    tick();
    checks++;
    if (bus.out !== '0) begin
      errors++;
      $display("FAIL restart_idle got %0d want 0", bus.out);
    end
  endtask

  task automatic test_back_to_back();
    int sv;
    for (int c = 0; c < 5; c++) begin
      sv = int'($urandom_range(1, N - 1));
      bus.stage = idx_t'(sv);
      bus.start = 1'b1;
      tick();
      checks++;
      if (bus.out !== '0) begin
        errors++;
        $display("FAIL b2b_hold c=%0d got %0d want 0", c, bus.out);
      end
    end
    bus.start = 1'b0;
    for (int j = 1; j < 6; j++) begin
      tick();
      checks++;
      if (bus.out !== idx_t'(ref_k(sv, j))) begin
        errors++;
        $display("FAIL b2b_run j=%0d got %0d want %0d", j, bus.out, ref_k(sv, j));
      end
    end
    for (int j = 6; j < HALF + 2; j++) tick();
  endtask

  task automatic test_reset_mid_sweep();
    bus.stage = idx_t'(32);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (bus.out !== '0) begin
        errors++;
        $display("FAIL rst_mid t=%0d got %0d want 0", t, bus.out);
      end
`ifdef TWIDDLE_FACTOR_INDEX_BUSY_EN
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_busy t=%0d got %0b want 0", t, bus.busy);
      end
`endif
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stage = '0;
    test_reset();
    test_sweep("span32", 32);
    test_restart();
    test_sweep("span1", 1);
    test_sweep("span16", 16);
    test_sweep("span6", 6);
    test_sweep("span63", 63);
    test_sweep("span0", 0);
    test_sweep("span8", 8);
    for (int r = 0; r < 6; r++)
      test_sweep("random", int'($urandom_range(0, N - 1)));
    test_back_to_back();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
